// File: rtl/mul6_seq_ctrl.sv
// mul6_seq_ctrl: 6x6 unsigned multiplier that time-multiplexes a single
// combinational 3x3 core over up to four steps, with valid/ready handshakes
// on the operand and result sides.
// Optional build macro: MUL_SKIP_ZERO_EN. When defined, steps whose partial
// product is known to be zero are skipped, which shortens the latency.

// Combinational 3x3 unsigned multiplier core
module mul_3x3 (
  input  logic [2:0] x,
  input  logic [2:0] y,
  output logic [5:0] prod
);
  assign prod = 6'(x) * 6'(y);
endmodule

module mul6_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  a,
  input  logic [5:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] p,
  output logic        busy
);
  localparam int unsigned HALF_W = 3;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned PP_W   = 6;
  localparam int unsigned ACC_W  = 12;
  localparam int unsigned STEPS  = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [OP_W-1:0]      a_q, b_q;
  logic [1:0]           step_q;
  logic [STEPS-1:0]     mask_q;

  logic [STEPS-1:0]     mask_c;
  logic [STEPS-1:0]     mask_rem_c;
  logic [HALF_W-1:0]    x_c, y_c;
  logic [PP_W-1:0]      pp_c;
  logic [3:0]           shift_c;
  logic [ACC_W-1:0]     sum_c;

  // Index of the lowest set bit in a step mask (mask assumed nonzero)
  function automatic logic [1:0] first_set(input logic [STEPS-1:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Step mask evaluated from the offered operands at acceptance
`ifdef MUL_SKIP_ZERO_EN
  always_comb begin
    mask_c[0] = (a[2:0] != 3'd0) && (b[2:0] != 3'd0);
    mask_c[1] = (a[2:0] != 3'd0) && (b[5:3] != 3'd0);
    mask_c[2] = (a[5:3] != 3'd0) && (b[2:0] != 3'd0);
    mask_c[3] = (a[5:3] != 3'd0) && (b[5:3] != 3'd0);
  end
`else
  assign mask_c = 4'b1111;
`endif

  // Operand half selection: step bit 1 picks the high half of a, bit 0 of b
  always_comb begin
    x_c        = step_q[1] ? a_q[5:3] : a_q[2:0];
    y_c        = step_q[0] ? b_q[5:3] : b_q[2:0];
    shift_c    = 4'(HALF_W) * (4'(step_q[0]) + 4'(step_q[1]));
    mask_rem_c = mask_q & ~(4'(1) << step_q);
  end

  mul_3x3 u_mul (
    .x    (x_c),
    .y    (y_c),
    .prod (pp_c)
  );

  assign sum_c = p + (ACC_W'(pp_c) << shift_c);

  // Control FSM, operand capture and accumulator; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      step_q    <= '0;
      mask_q    <= '0;
      p         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            p        <= '0;
            mask_q   <= mask_c;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (mask_c != '0) begin
              step_q <= first_set(mask_c);
              state  <= RUN;
            end else begin
              step_q    <= '0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          p      <= sum_c;
          mask_q <= mask_rem_c;
          if (mask_rem_c != '0) begin
            step_q <= first_set(mask_rem_c);
          end else begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            step_q    <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul6_seq_ctrl.sv
// Testbench for mul6_seq_ctrl: table of directed operand pairs with
// hand-computed products and latencies, plus stall and reset sequences.
module tb_mul6_seq_ctrl;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] p;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  mul6_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] p;
    int          lat_full;
    int          lat_skip;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input vec_t v);
`ifdef MUL_SKIP_ZERO_EN
    return v.lat_skip;
`else
    return v.lat_full;
`endif
  endfunction

  // Offer one operand pair, measure latency, check product and handshake
  task automatic run_op(input logic [5:0] av, input logic [5:0] bv,
                        input int exp_p, input int lat);
    int n;
    @(negedge clk);
    chk("in_ready_before_accept", int'(in_ready), 1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 6'h2a;
    b = 6'h15;
    chk("in_ready_after_accept", int'(in_ready), 0);
    chk("busy_after_accept", int'(busy), 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("out_valid_seen", int'(out_valid), 1);
    chk("latency", n, lat);
    chk("product", int'(p), exp_p);
    @(posedge clk);
    #1;
    chk("in_ready_after_handshake", int'(in_ready), 1);
    chk("out_valid_after_handshake", int'(out_valid), 0);
    chk("busy_after_handshake", int'(busy), 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{6'd63, 6'd63, 12'd3969, 4, 4};
    vecs[1] = '{6'd5,  6'd6,  12'd30,   4, 1};
    vecs[2] = '{6'd56, 6'd7,  12'd392,  4, 1};
    vecs[3] = '{6'd0,  6'd45, 12'd0,    4, 0};
    vecs[4] = '{6'd7,  6'd56, 12'd392,  4, 1};
    vecs[5] = '{6'd36, 6'd5,  12'd180,  4, 2};
    vecs[6] = '{6'd1,  6'd63, 12'd63,   4, 2};
    vecs[7] = '{6'd63, 6'd1,  12'd63,   4, 2};
    vecs[8] = '{6'd0,  6'd0,  12'd0,    4, 0};
    vecs[9] = '{6'd9,  6'd9,  12'd81,   4, 4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_p", int'(p), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, int'(vecs[i].p), exp_lat(vecs[i]));
    end

    // Stall in DONE with out_ready low; in_valid pulses must be ignored
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a = 6'd9;
    b = 6'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_latency", n, exp_lat(vecs[9]));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = 6'd3 + 6'(i);
      b = 6'd7;
      chk("stall_out_valid", int'(out_valid), 1);
      chk("stall_p", int'(p), 81);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("release_idle_busy", int'(busy), 0);
    chk("release_idle_p_kept", int'(p), 81);

    // Reset two cycles into an operation discards it
    @(negedge clk);
    in_valid = 1'b1;
    a = 6'd63;
    b = 6'd63;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_p", int'(p), 0);
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_in_ready", int'(in_ready), 1);
    chk("midreset_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef MUL_SKIP_ZERO_EN
    run_op(6'd2, 6'd3, 6, 1);
`else
    run_op(6'd2, 6'd3, 6, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
